// File: rtl/nonogram_pkg.sv
// Shared types and sizing helpers for the nonogram board pipeline.
package nonogram_pkg;

  localparam int DEF_MAX_ROWS = 11;
  localparam int DEF_MAX_COLS = 11;

  typedef enum logic [1:0] {
    ST_RECEIVE  = 2'd0,
    ST_SOLVE    = 2'd1,
    ST_TRANSMIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERFLOW = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_BAD_DIM  = 2'd3
  } err_t;

  // Bits needed to hold a dimension value 0..max_dim inclusive.
  function automatic int dim_w(input int max_dim);
    return $clog2(max_dim + 1);
  endfunction

endpackage

// File: rtl/puzzle_sequencer_watchdog.sv
// Solve-phase watchdog: clearable up-counter that flags its final cycle.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Hold at the limit so the count never wraps back into the valid window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != LIMIT))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register; cleared by reset and whenever the sequencer is outside SOLVE.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/puzzle_sequencer.sv
// Board-level RECEIVE/SOLVE/TRANSMIT sequencer with FIFO write mux,
// dimension/solution latches, watchdog, fault handling and board counter.
module puzzle_sequencer
  import nonogram_pkg::*;
#(
  parameter int MAX_ROWS       = DEF_MAX_ROWS,
  parameter int MAX_COLS       = DEF_MAX_COLS,
  parameter int LINE_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int ROW_W          = dim_w(MAX_ROWS),
  parameter int COL_W          = dim_w(MAX_COLS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         abort,
  input  logic                         parse_done,
  input  logic                         parse_write,
  input  logic [LINE_WIDTH-1:0]        parse_line,
  input  logic [ROW_W-1:0]             m_in,
  input  logic [COL_W-1:0]             n_in,
  input  logic                         solve_write,
  input  logic [LINE_WIDTH-1:0]        solve_line,
  input  logic                         solved,
  input  logic [MAX_ROWS*MAX_COLS-1:0] solution_in,
  input  logic                         assembled,
  input  logic                         fifo_full,
  input  logic                         fifo_empty,
  output logic                         fifo_wr,
  output logic [LINE_WIDTH-1:0]        fifo_din,
  output logic                         fifo_srst,
  output logic                         solver_rst,
  output logic [ROW_W-1:0]             m_out,
  output logic [COL_W-1:0]             n_out,
  output logic [MAX_ROWS*MAX_COLS-1:0] solution_out,
  output logic [1:0]                   state,
  output logic [1:0]                   err,
  output logic [2:0]                   stat,
  output logic [7:0]                   board_count
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(MAX_ROWS);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_COLS);

  state_t state_q, state_d;
  err_t   err_q, err_d;
  logic   flush_q, flush_d;

  logic lat_dim, lat_sol, inc_cnt;
  logic sel_wr, overflow, dim_ok, wd_expired;

  logic [ROW_W-1:0]             m_q;
  logic [COL_W-1:0]             n_q;
  logic [MAX_ROWS*MAX_COLS-1:0] sol_q;
  logic [7:0]                   cnt_q;

  assign dim_ok   = (m_in != '0) && (m_in <= ROW_MAX) &&
                    (n_in != '0) && (n_in <= COL_MAX);
  assign overflow = sel_wr && fifo_full;

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q != ST_SOLVE),
    .en_i      (state_q == ST_SOLVE),
    .expired_o (wd_expired)
  );

  // State register with sticky error code and registered flush pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RECEIVE;
      err_q   <= ERR_NONE;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic; branch order encodes abort > overflow > solved > timeout > normal.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    flush_d = 1'b0;
    lat_dim = 1'b0;
    lat_sol = 1'b0;
    inc_cnt = 1'b0;
    if (abort) begin
      state_d = ST_RECEIVE;
      if (state_q == ST_FAULT)
        err_d = ERR_NONE;
      else
        flush_d = 1'b1;
    end else if (overflow) begin
      state_d = ST_FAULT;
      err_d   = ERR_OVERFLOW;
      flush_d = 1'b1;
    end else begin
      case (state_q)
        ST_RECEIVE: begin
          if (parse_done) begin
            if (dim_ok) begin
              state_d = ST_SOLVE;
              lat_dim = 1'b1;
            end else begin
              state_d = ST_FAULT;
              err_d   = ERR_BAD_DIM;
              flush_d = 1'b1;
            end
          end
        end
        ST_SOLVE: begin
          if (solved) begin
            state_d = ST_TRANSMIT;
            lat_sol = 1'b1;
            flush_d = 1'b1;
          end else if (wd_expired) begin
            state_d = ST_FAULT;
            err_d   = ERR_TIMEOUT;
            flush_d = 1'b1;
          end
        end
        ST_TRANSMIT: begin
          if (assembled) begin
            state_d = ST_RECEIVE;
            inc_cnt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO write mux: the current state picks the source; a full FIFO blocks the write.
  always_comb begin
    sel_wr   = 1'b0;
    fifo_din = '0;
    case (state_q)
      ST_RECEIVE: begin
        sel_wr   = parse_write;
        fifo_din = parse_line;
      end
      ST_SOLVE: begin
        sel_wr   = solve_write;
        fifo_din = solve_line;
      end
      default: ;
    endcase
    fifo_wr = sel_wr && !fifo_full;
  end

  // Dimension/solution latches and completed-board counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q   <= '0;
      n_q   <= '0;
      sol_q <= '0;
      cnt_q <= '0;
    end else begin
      if (lat_dim) begin
        m_q <= m_in;
        n_q <= n_in;
      end
      if (lat_sol)
        sol_q <= solution_in;
      if (inc_cnt)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  assign fifo_srst    = rst || flush_q;
  assign solver_rst   = flush_q;
  assign m_out        = m_q;
  assign n_out        = n_q;
  assign solution_out = sol_q;
  assign state        = state_q;
  assign err          = err_q;
  assign stat         = {state_q, fifo_empty};
  assign board_count  = cnt_q;

endmodule

// File: tb/tb_puzzle_sequencer.sv
// Self-checking bench for puzzle_sequencer: randomized boards against a
// scoreboard of expected latches/counter, plus fault and priority scenarios.
module tb_puzzle_sequencer;

  localparam int MR = 11;
  localparam int MC = 11;
  localparam int LW = 16;
  localparam int TO = 8;
  localparam int RW = $clog2(MR + 1);
  localparam int CW = $clog2(MC + 1);
  localparam int SW = MR * MC;

  logic          clk = 1'b0;
  logic          rst, abort, parse_done, parse_write, solve_write;
  logic          solved, assembled, fifo_full, fifo_empty;
  logic [LW-1:0] parse_line, solve_line, fifo_din;
  logic [RW-1:0] m_in, m_out;
  logic [CW-1:0] n_in, n_out;
  logic [SW-1:0] solution_in, solution_out;
  logic          fifo_wr, fifo_srst, solver_rst;
  logic [1:0]    state, err;
  logic [2:0]    stat;
  logic [7:0]    board_count;

  int checks   = 0;
  int failures = 0;
  int flush_cnt = 0;

  // Reference scoreboard: what the latches and counter should hold.
  int            exp_count;
  logic [RW-1:0] exp_m;
  logic [CW-1:0] exp_n;
  logic [SW-1:0] exp_sol;

  puzzle_sequencer #(
    .MAX_ROWS(MR), .MAX_COLS(MC), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .abort(abort), .parse_done(parse_done),
    .parse_write(parse_write), .parse_line(parse_line), .m_in(m_in), .n_in(n_in),
    .solve_write(solve_write), .solve_line(solve_line), .solved(solved),
    .solution_in(solution_in), .assembled(assembled), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
    .fifo_srst(fifo_srst), .solver_rst(solver_rst), .m_out(m_out), .n_out(n_out),
    .solution_out(solution_out), .state(state), .err(err), .stat(stat),
    .board_count(board_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (solver_rst === 1'b1) flush_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout sim time exceeded, checks=%0d", checks);
    $fatal(1, "bench did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] rand_sol();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[SW-1:0];
  endfunction

  task automatic enter_solve(input int m, input int n);
    parse_done = 1'b1; m_in = RW'(m); n_in = CW'(n);
    step();
    parse_done = 1'b0;
    exp_m = RW'(m); exp_n = CW'(n);
  endtask

  task automatic drive_board();
    logic [SW-1:0] s;
    int m, n;
    m = $urandom_range(1, MR); n = $urandom_range(1, MC); s = rand_sol();
    enter_solve(m, n);
    solved = 1'b1; solution_in = s;
    step();
    solved = 1'b0; exp_sol = s;
    assembled = 1'b1;
    step();
    assembled = 1'b0; exp_count = (exp_count + 1) % 256;
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_empty = 1'b1;
    step(); step();
    checks++; if (fifo_srst !== 1'b1) begin failures++; $display("FAIL reset_srst got=%b exp=1", fifo_srst); end
    checks++; if (solver_rst !== 1'b0) begin failures++; $display("FAIL reset_solver_rst got=%b exp=0", solver_rst); end
    rst = 1'b0;
    #1;
    checks++; if (fifo_srst !== 1'b0) begin failures++; $display("FAIL reset_srst_release got=%b exp=0", fifo_srst); end
    exp_count = 0; exp_m = '0; exp_n = '0; exp_sol = '0;
    checks++; if (state !== 2'd0 || err !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d/%0d exp=0/0", state, err); end
    checks++; if (m_out !== exp_m || n_out !== exp_n || solution_out !== exp_sol) begin failures++; $display("FAIL reset_latches got m=%0d n=%0d exp 0", m_out, n_out); end
    checks++; if (board_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", board_count); end
    checks++; if (stat !== 3'b001) begin failures++; $display("FAIL reset_stat got=%b exp=001", stat); end
    step();
  endtask

  task automatic test_normal();
    int m, n, nl, lat;
    logic [LW-1:0] ln;
    logic [SW-1:0] s;
    for (int b = 0; b < 6; b++) begin
      m = $urandom_range(1, MR); n = $urandom_range(1, MC);
      nl = $urandom_range(1, 3); lat = $urandom_range(0, TO - 1);
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL normal_idle got=%0d exp=0", state); end
      for (int i = 0; i < nl; i++) begin
        ln = LW'($urandom); parse_write = 1'b1; parse_line = ln;
        if (i == nl - 1) begin parse_done = 1'b1; m_in = RW'(m); n_in = CW'(n); end
        #1;
        checks++; if (fifo_wr !== 1'b1 || fifo_din !== ln) begin failures++; $display("FAIL normal_parse_fwd got wr=%b din=%h exp wr=1 din=%h", fifo_wr, fifo_din, ln); end
        step();
      end
      parse_write = 1'b0; parse_done = 1'b0; exp_m = RW'(m); exp_n = CW'(n);
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL normal_to_solve got=%0d exp=1", state); end
      checks++; if (m_out !== exp_m || n_out !== exp_n) begin failures++; $display("FAIL normal_dims got=%0d,%0d exp=%0d,%0d", m_out, n_out, exp_m, exp_n); end
      for (int i = 0; i < lat; i++) begin
        ln = LW'($urandom); solve_write = 1'b1; solve_line = ln;
        parse_write = 1'b1; parse_line = ~ln; assembled = 1'b1;
        #1;
        checks++; if (fifo_wr !== 1'b1 || fifo_din !== ln) begin failures++; $display("FAIL normal_solve_fwd got wr=%b din=%h exp wr=1 din=%h", fifo_wr, fifo_din, ln); end
        step();
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL normal_solve_hold got=%0d exp=1", state); end
      end
      solve_write = 1'b0; parse_write = 1'b0; assembled = 1'b0;
      s = rand_sol(); solved = 1'b1; solution_in = s;
      step();
      solved = 1'b0; exp_sol = s;
      checks++; if (state !== 2'd2 || solution_out !== exp_sol) begin failures++; $display("FAIL normal_to_transmit got state=%0d sol_ok=%b exp state=2", state, solution_out === exp_sol); end
      checks++; if (fifo_srst !== 1'b1 || solver_rst !== 1'b1) begin failures++; $display("FAIL normal_flush got=%b%b exp=11", fifo_srst, solver_rst); end
      solved = 1'b1; solution_in = ~s; solve_write = 1'b1; parse_write = 1'b1;
      parse_done = 1'b1; m_in = RW'($urandom_range(1, MR)); n_in = CW'($urandom_range(1, MC));
      #1;
      checks++; if (fifo_wr !== 1'b0 || fifo_din !== '0) begin failures++; $display("FAIL normal_tx_mux got wr=%b din=%h exp 0/0", fifo_wr, fifo_din); end
      step();
      solved = 1'b0; solve_write = 1'b0; parse_write = 1'b0; parse_done = 1'b0;
      checks++; if (state !== 2'd2 || solution_out !== exp_sol || m_out !== exp_m) begin failures++; $display("FAIL normal_tx_ignore got state=%0d m=%0d exp state=2 m=%0d", state, m_out, exp_m); end
      checks++; if (fifo_srst !== 1'b0) begin failures++; $display("FAIL normal_flush_width got=%b exp=0", fifo_srst); end
      assembled = 1'b1;
      step();
      assembled = 1'b0; exp_count = (exp_count + 1) % 256;
      checks++; if (state !== 2'd0 || board_count !== 8'(exp_count)) begin failures++; $display("FAIL normal_done got state=%0d cnt=%0d exp 0/%0d", state, board_count, exp_count); end
    end
  endtask

  task automatic test_bad_dim();
    int c, m, n, fc;
    for (int k = 0; k < 4; k++) begin
      m = $urandom_range(1, MR); n = $urandom_range(1, MC);
      c = (k == 0) ? 0 : $urandom_range(0, 3);
      case (c)
        0: m = (k == 0) ? 12 : $urandom_range(MR + 1, 15);
        1: m = 0;
        2: n = 0;
        default: n = $urandom_range(MC + 1, 15);
      endcase
      fc = flush_cnt;
      parse_done = 1'b1; m_in = RW'(m); n_in = CW'(n);
      step();
      parse_done = 1'b0;
      checks++; if (state !== 2'd3 || err !== 2'd3) begin failures++; $display("FAIL baddim_fault m=%0d n=%0d got=%0d/%0d exp=3/3", m, n, state, err); end
      checks++; if (fifo_srst !== 1'b1 || solver_rst !== 1'b1) begin failures++; $display("FAIL baddim_flush got=%b%b exp=11", fifo_srst, solver_rst); end
      checks++; if (m_out !== exp_m || n_out !== exp_n) begin failures++; $display("FAIL baddim_nolatch got=%0d,%0d exp=%0d,%0d", m_out, n_out, exp_m, exp_n); end
      parse_write = 1'b1; parse_line = LW'($urandom);
      #1;
      checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL baddim_fault_mux got=%b exp=0", fifo_wr); end
      repeat (4) step();
      parse_write = 1'b0;
      checks++; if (flush_cnt - fc !== 1 || state !== 2'd3 || err !== 2'd3) begin failures++; $display("FAIL baddim_hold flushes=%0d state=%0d err=%0d exp 1/3/3", flush_cnt - fc, state, err); end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++; if (state !== 2'd0 || err !== 2'd0) begin failures++; $display("FAIL baddim_abort got=%0d/%0d exp=0/0", state, err); end
    end
  endtask

  task automatic test_overflow();
    enter_solve($urandom_range(1, MR), $urandom_range(1, MC));
    solve_write = 1'b1; solve_line = LW'($urandom); fifo_full = 1'b1;
    #1;
    checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL ovf_block got=%b exp=0", fifo_wr); end
    step();
    solve_write = 1'b0; fifo_full = 1'b0;
    checks++; if (state !== 2'd3 || err !== 2'd1 || fifo_srst !== 1'b1) begin failures++; $display("FAIL ovf_solve got state=%0d err=%0d srst=%b exp 3/1/1", state, err, fifo_srst); end
    abort = 1'b1; step(); abort = 1'b0;
    parse_write = 1'b1; fifo_full = 1'b1; parse_done = 1'b1;
    m_in = RW'($urandom_range(1, MR)); n_in = CW'($urandom_range(1, MC));
    if (m_in == exp_m) m_in = (m_in == RW'(1)) ? RW'(2) : RW'(1);
    step();
    parse_write = 1'b0; fifo_full = 1'b0; parse_done = 1'b0;
    checks++; if (state !== 2'd3 || err !== 2'd1 || m_out !== exp_m) begin failures++; $display("FAIL ovf_beats_done got state=%0d err=%0d m=%0d exp 3/1/%0d", state, err, m_out, exp_m); end
    abort = 1'b1; step(); abort = 1'b0;
    fifo_full = 1'b1;
    step();
    fifo_full = 1'b0;
    checks++; if (state !== 2'd0 || err !== 2'd0) begin failures++; $display("FAIL ovf_idle_full got=%0d/%0d exp=0/0", state, err); end
  endtask

  task automatic test_timeout();
    logic [SW-1:0] s;
    enter_solve($urandom_range(1, MR), $urandom_range(1, MC));
    repeat (TO - 1) step();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL tmo_before got=%0d exp=1", state); end
    step();
    checks++; if (state !== 2'd3 || err !== 2'd2 || fifo_srst !== 1'b1) begin failures++; $display("FAIL tmo_fault got state=%0d err=%0d srst=%b exp 3/2/1", state, err, fifo_srst); end
    abort = 1'b1; step(); abort = 1'b0;
    enter_solve($urandom_range(1, MR), $urandom_range(1, MC));
    repeat (TO - 1) step();
    s = rand_sol(); solved = 1'b1; solution_in = s;
    step();
    solved = 1'b0; exp_sol = s;
    checks++; if (state !== 2'd2 || err !== 2'd0 || solution_out !== exp_sol) begin failures++; $display("FAIL tmo_last_solve got state=%0d err=%0d exp 2/0", state, err); end
    assembled = 1'b1; step(); assembled = 1'b0;
    exp_count = (exp_count + 1) % 256;
    checks++; if (board_count !== 8'(exp_count)) begin failures++; $display("FAIL tmo_count got=%0d exp=%0d", board_count, exp_count); end
  endtask

  task automatic test_abort();
    enter_solve($urandom_range(1, MR), $urandom_range(1, MC));
    solved = 1'b1; abort = 1'b1; solution_in = ~exp_sol;
    step();
    solved = 1'b0; abort = 1'b0;
    checks++; if (state !== 2'd0 || solution_out !== exp_sol || err !== 2'd0) begin failures++; $display("FAIL abort_vs_solved got state=%0d err=%0d exp 0/0", state, err); end
    checks++; if (fifo_srst !== 1'b1 || solver_rst !== 1'b1) begin failures++; $display("FAIL abort_flush got=%b%b exp=11", fifo_srst, solver_rst); end
    enter_solve($urandom_range(1, MR), $urandom_range(1, MC));
    solve_write = 1'b1; fifo_full = 1'b1; abort = 1'b1;
    step();
    solve_write = 1'b0; fifo_full = 1'b0; abort = 1'b0;
    checks++; if (state !== 2'd0 || err !== 2'd0) begin failures++; $display("FAIL abort_vs_ovf got=%0d/%0d exp=0/0", state, err); end
    enter_solve($urandom_range(1, MR), $urandom_range(1, MC));
    solved = 1'b1; solution_in = rand_sol(); exp_sol = solution_in;
    step();
    solved = 1'b0;
    assembled = 1'b1; abort = 1'b1;
    step();
    assembled = 1'b0; abort = 1'b0;
    checks++; if (state !== 2'd0 || board_count !== 8'(exp_count) || fifo_srst !== 1'b1) begin failures++; $display("FAIL abort_vs_assembled got state=%0d cnt=%0d exp 0/%0d", state, board_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    enter_solve(3, 4);
    rst = 1'b1;
    step();
    rst = 1'b0; exp_count = 0; exp_m = '0; exp_n = '0; exp_sol = '0;
    checks++; if (state !== 2'd0 || m_out !== exp_m || n_out !== exp_n || board_count !== 8'd0) begin failures++; $display("FAIL rst_mid got state=%0d m=%0d cnt=%0d exp 0/0/0", state, m_out, board_count); end
    for (int b = 0; b < 255; b++) drive_board();
    checks++; if (board_count !== 8'(exp_count) || exp_count != 255) begin failures++; $display("FAIL b2b_255 got=%0d exp=255", board_count); end
    drive_board();
    checks++; if (board_count !== 8'd0) begin failures++; $display("FAIL b2b_wrap got=%0d exp=0", board_count); end
    checks++; if (m_out !== exp_m || n_out !== exp_n || solution_out !== exp_sol) begin failures++; $display("FAIL b2b_latches got m=%0d n=%0d exp %0d/%0d", m_out, n_out, exp_m, exp_n); end
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; parse_done = 1'b0; parse_write = 1'b0; solve_write = 1'b0;
    solved = 1'b0; assembled = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b0;
    parse_line = '0; solve_line = '0; m_in = '0; n_in = '0; solution_in = '0;
    test_reset();
    test_normal();
    test_bad_dim();
    test_overflow();
    test_timeout();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
